// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the instruction-memory read
// handshake and holds the fetched word in the instruction register.
module fetch_unit #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = '0,
  parameter int unsigned          pcmux_N  = 2,
  localparam int unsigned         SELW     = (pcmux_N > 1) ? $clog2(pcmux_N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instrre,
  input  logic            pcnextctl,
  input  logic [SELW-1:0] pcmuxctl,
  input  logic [XLEN-1:0] brtarget,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus4,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic            fetch_busy,
  output logic            misaligned,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic            func7b5,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2
);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= NOP;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      // PC update is independent of the handshake; imem_addr captures the old pc.
      if (pcnextctl) begin
        if (pcmuxctl == SELW'(0)) begin
          pc <= pcplus4;
        end else if (pcmuxctl == SELW'(1)) begin
          if (brtarget[1:0] == 2'b00) pc <= brtarget;
          else                        misaligned <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          if (instrre) begin
            imem_req    <= 1'b1;
            imem_addr   <= pc;
            instr_valid <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pcplus4    = pc + XLEN'(4);
  assign fetch_busy = (state == WAIT);

  assign opcode  = instr[6:0];
  assign func3   = instr[14:12];
  assign func7b5 = instr[30];
  assign rd      = instr[11:7];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];

endmodule
